aes_iter_cipher: RTL and testbench

Iterative AES encryption core (FIPS-197 Cipher); the forward counterpart of the inverse cipher used on the decryption side. Expands the key sequentially, one word per cycle, into an internal schedule. Then executes one round per cycle. Valid/ready on both sides, so it sits between a plaintext source and a ciphertext sink in the encryption datapath.

---
 rtl/aes_pkg.sv | 80 ++++++++
 rtl/aes_enc_round.sv | 35 +++
 rtl/aes_iter_cipher.sv | 202 ++++++++++++++++++++
 tb/tb_aes_iter_cipher.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions for the forward and inverse iterative ciphers:
// S-box, Rcon, GF(2^8) helpers, FSM encoding and word/byte/block types.
package aes_pkg;

    typedef logic [7:0]   byte_t;
    typedef logic [31:0]  word_t;
    typedef logic [127:0] block_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_KEXP,
        ST_ROUND,
        ST_DONE
    } aes_state_e;

    // Entry 0 sits in the most significant byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic byte_t sbox(input byte_t b);
        return SBOX_TBL[{~b, 3'b000} +: 8];
    endfunction

    function automatic word_t sub_word(input word_t w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic byte_t rcon(input logic [3:0] j);
        case (j)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic word_t mix_column(input word_t c);
        byte_t a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round; i_last drops MixColumns for the
// final round. Byte n of the block is row n%4, column n/4.
module aes_enc_round
    import aes_pkg::*;
(
    input  logic [127:0] i_state,
    input  logic [127:0] i_rkey,
    input  logic         i_last,
    output logic [127:0] o_state
);

    logic [127:0] sb;
    logic [127:0] sr;
    logic [127:0] mc;

    always_comb begin
        sb = '0;
        sr = '0;
        mc = '0;
        for (int n = 0; n < 16; n++) begin
            sb[127-8*n -: 8] = sbox(i_state[127-8*n -: 8]);
        end
        // Row r rotates left by r columns.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[127-8*(r+4*c) -: 8] = sb[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc[127-32*c -: 32] = mix_column(sr[127-32*c -: 32]);
        end
        o_state = (i_last ? sr : mc) ^ i_rkey;
    end

endmodule

// File: rtl/aes_iter_cipher.sv
// Iterative AES cipher: sequential key expansion then one round per cycle.
// Optional define KEY_CACHE_EN skips expansion when the key repeats.
module aes_iter_cipher
    import aes_pkg::*;
#(
    parameter int NK = 4,
    parameter int NR = 10
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [127:0]    i_data,
    input  logic [32*NK-1:0] i_key,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [127:0]    o_data
);

    localparam int NW    = 4 * (NR + 1);
    localparam int IDX_W = $clog2(NW);
    localparam int R_W   = $clog2(NR + 1);
    localparam logic [IDX_W-1:0] W_FIRST = IDX_W'(NK);
    localparam logic [IDX_W-1:0] W_LAST  = IDX_W'(NW - 1);

    generate
        if (NR != NK + 6 || !(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_cfg
            $error("aes_iter_cipher: unsupported NK/NR pair");
        end
    endgenerate

    aes_state_e       state_q, state_d;
    logic [IDX_W-1:0] widx_q, widx_d;
    logic [2:0]       kmod_q, kmod_d;
    logic [3:0]       kdiv_q, kdiv_d;
    logic [R_W-1:0]   rnd_q, rnd_d;
    logic [127:0]     blk_q, blk_d;
    logic [127:0]     odata_q, odata_d;
    word_t            w_q [NW];

    logic             accept;
    logic             cache_hit;
    logic             kexp_last;
    word_t            w_prev, w_far, w_temp, w_new;
    logic [IDX_W-1:0] rk_base;
    logic [127:0]     rkey;
    logic [127:0]     round_out;
    logic             round_last;

    assign accept    = (state_q == ST_IDLE) && i_valid;
    assign kexp_last = (state_q == ST_KEXP) && (widx_q == W_LAST);

    // kmod/kdiv track i mod NK and i / NK without a divider.
    always_comb begin
        w_prev = w_q[widx_q - IDX_W'(1)];
        w_far  = w_q[widx_q - W_FIRST];
        if (kmod_q == 3'd0) begin
            w_temp = sub_word(rot_word(w_prev)) ^ {rcon(kdiv_q), 24'h0};
        end else if (NK == 8 && kmod_q == 3'd4) begin
            w_temp = sub_word(w_prev);
        end else begin
            w_temp = w_prev;
        end
        w_new = w_far ^ w_temp;
    end

    assign rk_base    = IDX_W'({rnd_q, 2'b00});
    assign rkey       = {w_q[rk_base], w_q[rk_base + IDX_W'(1)],
                         w_q[rk_base + IDX_W'(2)], w_q[rk_base + IDX_W'(3)]};
    assign round_last = (rnd_q == R_W'(NR));

    aes_enc_round u_round (
        .i_state (blk_q),
        .i_rkey  (rkey),
        .i_last  (round_last),
        .o_state (round_out)
    );

`ifdef KEY_CACHE_EN
    logic             kc_vld_q, kc_vld_d;
    logic [32*NK-1:0] kc_key_q, kc_key_d;

    assign cache_hit = kc_vld_q && (i_key == kc_key_q);

    always_comb begin
        kc_vld_d = kc_vld_q;
        kc_key_d = kc_key_q;
        if (accept && !cache_hit) begin
            kc_vld_d = 1'b0;
            kc_key_d = i_key;
        end else if (kexp_last) begin
            kc_vld_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            kc_vld_q <= 1'b0;
            kc_key_q <= '0;
        end else begin
            kc_vld_q <= kc_vld_d;
            kc_key_q <= kc_key_d;
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        widx_d  = widx_q;
        kmod_d  = kmod_q;
        kdiv_d  = kdiv_q;
        rnd_d   = rnd_q;
        blk_d   = blk_q;
        odata_d = odata_q;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    blk_d = i_data ^ i_key[32*NK-1 -: 128];
                    if (cache_hit) begin
                        state_d = ST_ROUND;
                        rnd_d   = R_W'(1);
                    end else begin
                        state_d = ST_KEXP;
                        widx_d  = W_FIRST;
                        kmod_d  = 3'd0;
                        kdiv_d  = 4'd1;
                    end
                end
            end
            ST_KEXP: begin
                widx_d = widx_q + IDX_W'(1);
                if (kmod_q == 3'(NK - 1)) begin
                    kmod_d = 3'd0;
                    kdiv_d = kdiv_q + 4'd1;
                end else begin
                    kmod_d = kmod_q + 3'd1;
                end
                if (widx_q == W_LAST) begin
                    state_d = ST_ROUND;
                    rnd_d   = R_W'(1);
                end
            end
            ST_ROUND: begin
                blk_d = round_out;
                rnd_d = rnd_q + R_W'(1);
                if (round_last) begin
                    odata_d = round_out;
                    rnd_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (i_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            widx_q  <= '0;
            kmod_q  <= '0;
            kdiv_q  <= '0;
            rnd_q   <= '0;
            blk_q   <= '0;
            odata_q <= '0;
        end else begin
            state_q <= state_d;
            widx_q  <= widx_d;
            kmod_q  <= kmod_d;
            kdiv_q  <= kdiv_d;
            rnd_q   <= rnd_d;
            blk_q   <= blk_d;
            odata_q <= odata_d;
        end
    end

    // Cipher key lands in w[0..NK-1]; expansion fills one word per cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NW; k++) begin
                w_q[k] <= '0;
            end
        end else if (accept) begin
            for (int k = 0; k < NK; k++) begin
                w_q[k] <= i_key[32*(NK-1-k) +: 32];
            end
        end else if (state_q == ST_KEXP) begin
            w_q[widx_q] <= w_new;
        end
    end

    assign o_ready = (state_q == ST_IDLE);
    assign o_valid = (state_q == ST_DONE);
    assign o_data  = odata_q;

endmodule

// File: tb/tb_aes_iter_cipher.sv
// Scoreboard bench for aes_iter_cipher with AES-128/192/256 instances.
module tb_aes_iter_cipher;

    localparam logic [127:0] PT_A = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_A = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [191:0] KEY_6 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [127:0] CT_6 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [255:0] KEY_8 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT_8 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT_B = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B = 128'h3925841d02dc09fbdc118597196a0b32;
`ifdef KEY_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   v, rin, ord, ov;
    logic [127:0] tdata;
    logic [255:0] tkey;
    logic [127:0] od [3];

    always #5 clk = ~clk;

    aes_iter_cipher #(.NK(4), .NR(10)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v[0]), .o_ready(ord[0]),
        .i_data(tdata), .i_key(tkey[255:128]), .o_valid(ov[0]),
        .i_ready(rin[0]), .o_data(od[0]));
    aes_iter_cipher #(.NK(6), .NR(12)) dut6 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v[1]), .o_ready(ord[1]),
        .i_data(tdata), .i_key(tkey[255:64]), .o_valid(ov[1]),
        .i_ready(rin[1]), .o_data(od[1]));
    aes_iter_cipher #(.NK(8), .NR(14)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v[2]), .o_ready(ord[2]),
        .i_data(tdata), .i_key(tkey), .o_valid(ov[2]),
        .i_ready(rin[2]), .o_data(od[2]));

    int           n_chk = 0;
    int           n_pass = 0;
    logic [127:0] exp_ct_q [$];
    int           exp_lat_q [$];
    bit           mdl_vld [3];
    logic [255:0] mdl_key [3];

    // Expected latency: full expansion plus rounds, or rounds only on a cache hit.
    task automatic send(input int sel, input logic [127:0] pt, input logic [255:0] key,
                        input logic [127:0] ct);
        int lat;
        lat = (CACHE && mdl_vld[sel] && mdl_key[sel] == key) ? 10 + 2*sel : 50 + 8*sel;
        mdl_vld[sel] = 1'b1;
        mdl_key[sel] = key;
        exp_ct_q.push_back(ct);
        exp_lat_q.push_back(lat);
        tdata  = pt;
        tkey   = key;
        v[sel] = 1'b1;
        @(posedge clk); #1;
        v[sel] = 1'b0;
    endtask

    task automatic wait_out(input int sel, output int lat, output bit to);
        lat = 0;
        to  = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            lat++;
            if (ov[sel]) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic release_out(input int sel);
        rin[sel] = 1'b1;
        @(posedge clk); #1;
        rin[sel] = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        v = '0; rin = '0; tdata = '0; tkey = '0;
        for (int s = 0; s < 3; s++) mdl_vld[s] = 1'b0;
        #12;
        for (int s = 0; s < 3; s++) begin
            n_chk++;
            if (ov[s] !== 1'b0) $display("FAIL reset_o_valid[%0d]: got %b expected 0", s, ov[s]);
            else n_pass++;
            n_chk++;
            if (ord[s] !== 1'b1) $display("FAIL reset_o_ready[%0d]: got %b expected 1", s, ord[s]);
            else n_pass++;
            n_chk++;
            if (od[s] !== 128'h0) $display("FAIL reset_o_data[%0d]: got %h expected 0", s, od[s]);
            else n_pass++;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_nk4;
        int lat, elat;
        bit to;
        logic [127:0] ect;
        send(0, PT_A, {KEY_A, 128'h0}, CT_A);
        wait_out(0, lat, to);
        ect = exp_ct_q.pop_front();
        elat = exp_lat_q.pop_front();
        n_chk++;
        if (to || lat !== elat) $display("FAIL nk4_latency: got %0d (timeout %0d) expected %0d", lat, to, elat);
        else n_pass++;
        n_chk++;
        if (od[0] !== ect) $display("FAIL nk4_data: got %h expected %h", od[0], ect);
        else n_pass++;
        release_out(0);
        n_chk++;
        if (ov[0] !== 1'b0 || ord[0] !== 1'b1)
            $display("FAIL nk4_handoff: got valid=%b ready=%b expected valid=0 ready=1", ov[0], ord[0]);
        else n_pass++;
    endtask

    task automatic test_backpressure;
        int lat, elat, bad;
        bit to;
        logic [127:0] ect, hold;
        send(0, PT_A, {KEY_A, 128'h0}, CT_A);
        wait_out(0, lat, to);
        ect = exp_ct_q.pop_front();
        elat = exp_lat_q.pop_front();
        n_chk++;
        if (to || lat !== elat) $display("FAIL bp_latency: got %0d (timeout %0d) expected %0d", lat, to, elat);
        else n_pass++;
        n_chk++;
        if (od[0] !== ect) $display("FAIL bp_data: got %h expected %h", od[0], ect);
        else n_pass++;
        hold = od[0];
        bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (ov[0] !== 1'b1 || od[0] !== hold || ord[0] !== 1'b0) bad++;
        end
        n_chk++;
        if (bad !== 0) $display("FAIL bp_hold: got %0d disturbed cycles expected 0", bad);
        else n_pass++;
        release_out(0);
        n_chk++;
        if (ov[0] !== 1'b0 || ord[0] !== 1'b1)
            $display("FAIL bp_release: got valid=%b ready=%b expected valid=0 ready=1", ov[0], ord[0]);
        else n_pass++;
    endtask

    task automatic test_busy_ignore;
        int lat, elat;
        bit to;
        logic [127:0] ect;
        send(0, PT_A, {KEY_A, 128'h0}, CT_A);
        lat = 0;
        to = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 5 || lat == 45) begin
                tdata = PT_B;
                tkey  = {KEY_B, 128'h0};
                v[0]  = 1'b1;
            end else begin
                v[0] = 1'b0;
            end
            if (ov[0]) begin
                to = 1'b0;
                break;
            end
        end
        v[0] = 1'b0;
        ect = exp_ct_q.pop_front();
        elat = exp_lat_q.pop_front();
        n_chk++;
        if (to || lat !== elat) $display("FAIL busy_latency: got %0d (timeout %0d) expected %0d", lat, to, elat);
        else n_pass++;
        n_chk++;
        if (od[0] !== ect) $display("FAIL busy_data: got %h expected %h", od[0], ect);
        else n_pass++;
        release_out(0);
    endtask

    task automatic test_reset_mid;
        int lat, elat;
        bit to;
        logic [127:0] ect;
        send(0, PT_B, {KEY_B, 128'h0}, CT_B);
        repeat (29) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (ov[0] !== 1'b0) $display("FAIL midrst_o_valid: got %b expected 0", ov[0]);
        else n_pass++;
        n_chk++;
        if (ord[0] !== 1'b1) $display("FAIL midrst_o_ready: got %b expected 1", ord[0]);
        else n_pass++;
        n_chk++;
        if (od[0] !== 128'h0) $display("FAIL midrst_o_data: got %h expected 0", od[0]);
        else n_pass++;
        exp_ct_q.delete();
        exp_lat_q.delete();
        for (int s = 0; s < 3; s++) mdl_vld[s] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(0, PT_A, {KEY_A, 128'h0}, CT_A);
        wait_out(0, lat, to);
        ect = exp_ct_q.pop_front();
        elat = exp_lat_q.pop_front();
        n_chk++;
        if (to || lat !== elat) $display("FAIL midrst_latency: got %0d (timeout %0d) expected %0d", lat, to, elat);
        else n_pass++;
        n_chk++;
        if (od[0] !== ect) $display("FAIL midrst_data: got %h expected %h", od[0], ect);
        else n_pass++;
        release_out(0);
    endtask

    task automatic test_key_sizes;
        int lat, elat;
        bit to;
        logic [127:0] ect;
        send(1, PT_A, {KEY_6, 64'h0}, CT_6);
        wait_out(1, lat, to);
        ect = exp_ct_q.pop_front();
        elat = exp_lat_q.pop_front();
        n_chk++;
        if (to || lat !== elat) $display("FAIL nk6_latency: got %0d (timeout %0d) expected %0d", lat, to, elat);
        else n_pass++;
        n_chk++;
        if (od[1] !== ect) $display("FAIL nk6_data: got %h expected %h", od[1], ect);
        else n_pass++;
        release_out(1);
        send(2, PT_A, KEY_8, CT_8);
        wait_out(2, lat, to);
        ect = exp_ct_q.pop_front();
        elat = exp_lat_q.pop_front();
        n_chk++;
        if (to || lat !== elat) $display("FAIL nk8_latency: got %0d (timeout %0d) expected %0d", lat, to, elat);
        else n_pass++;
        n_chk++;
        if (od[2] !== ect) $display("FAIL nk8_data: got %h expected %h", od[2], ect);
        else n_pass++;
        release_out(2);
    endtask

    task automatic test_back_to_back;
        int lat, elat;
        bit to;
        logic [127:0] ect;
        logic [127:0] pts [3];
        logic [127:0] keys [3];
        logic [127:0] cts [3];
        pts  = '{PT_B, PT_B, PT_A};
        keys = '{KEY_B, KEY_B, KEY_A};
        cts  = '{CT_B, CT_B, CT_A};
        for (int b = 0; b < 3; b++) begin
            send(0, pts[b], {keys[b], 128'h0}, cts[b]);
            wait_out(0, lat, to);
            ect = exp_ct_q.pop_front();
            elat = exp_lat_q.pop_front();
            n_chk++;
            if (to || lat !== elat)
                $display("FAIL b2b_latency[%0d]: got %0d (timeout %0d) expected %0d", b, lat, to, elat);
            else n_pass++;
            n_chk++;
            if (od[0] !== ect) $display("FAIL b2b_data[%0d]: got %h expected %h", b, od[0], ect);
            else n_pass++;
            release_out(0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_nk4();
        test_backpressure();
        test_busy_ignore();
        test_reset_mid();
        test_key_sizes();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
